// File: rtl/dmem_bus_arbiter_if.sv
// dmem_bus_arbiter_if: fetch, load/store and external bus handshake signals
interface dmem_bus_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic            data_req;
  logic            data_wr;
  logic [DW/8-1:0] data_wstrb;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [DW-1:0]   data_rdata;
  logic            bus_req;
  logic            bus_wr;
  logic [DW/8-1:0] bus_wstrb;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_addr_ok;
  logic            bus_data_ok;
  logic [DW-1:0]   bus_rdata;
  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );
  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_wstrb, data_addr, data_wdata,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
           bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: one-outstanding fetch/load-store bus arbiter; define DMEM_ARB_RR_EN for round-robin, else data has fixed priority
module dmem_bus_arbiter #(parameter int AW = 32, parameter int DW = 32) (
  input logic clk,
  input logic resetn,
  dmem_bus_arbiter_if.slave ifc
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t          r_state, w_next;
  logic            r_grant, r_wr;
  logic [DW/8-1:0] r_wstrb;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            w_any, w_pick_data, w_addr_ok, w_data_ok;
  assign w_any = ifc.inst_req | ifc.data_req;
`ifdef DMEM_ARB_RR_EN
  logic r_last;
  assign w_pick_data = ifc.data_req & (~ifc.inst_req | ~r_last);
  // remember the last winner so contended requests alternate
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_last <= 1'b0;
    else if (r_state == IDLE && w_any) r_last <= w_pick_data;
`else
  assign w_pick_data = ifc.data_req;
`endif
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  // next state and bus handshake decode
  always_comb begin
    w_next = r_state;
    w_addr_ok = 1'b0;
    w_data_ok = 1'b0;
    case (r_state)
      IDLE: w_next = w_any ? ADDR : IDLE;
      ADDR: begin
        w_addr_ok = ifc.bus_addr_ok;
        w_data_ok = ifc.bus_addr_ok & ifc.bus_data_ok;
        w_next = ifc.bus_addr_ok ? (ifc.bus_data_ok ? IDLE : DATA) : ADDR;
      end
      DATA: begin
        w_data_ok = ifc.bus_data_ok;
        w_next = ifc.bus_data_ok ? IDLE : DATA;
      end
      default: w_next = IDLE;
    endcase
  end
  // capture the winner and its request fields when a transaction starts
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_grant <= 1'b0;
      r_wr <= 1'b0;
      r_wstrb <= '0;
      r_addr <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_grant <= w_pick_data;
      r_wr <= w_pick_data & ifc.data_wr;
      r_wstrb <= w_pick_data ? ifc.data_wstrb : '0;
      r_addr <= w_pick_data ? ifc.data_addr : ifc.inst_addr;
      r_wdata <= w_pick_data ? ifc.data_wdata : '0;
    end
  assign ifc.bus_req = r_state == ADDR;
  assign ifc.bus_wr = r_wr;
  assign ifc.bus_wstrb = r_wstrb;
  assign ifc.bus_addr = r_addr;
  assign ifc.bus_wdata = r_wdata;
  assign ifc.inst_addr_ok = w_addr_ok & ~r_grant;
  assign ifc.inst_data_ok = w_data_ok & ~r_grant;
  assign ifc.data_addr_ok = w_addr_ok & r_grant;
  assign ifc.data_data_ok = w_data_ok & r_grant;
  assign ifc.inst_rdata = ifc.bus_rdata;
  assign ifc.data_rdata = ifc.bus_rdata;
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter: scoreboard bench for dmem_bus_arbiter with a transaction-level reference model
module tb_dmem_bus_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  dmem_bus_arbiter_if #(.AW(32), .DW(32)) ifc();
  dmem_bus_arbiter #(.AW(32), .DW(32)) dut(.clk(clk), .resetn(resetn), .ifc(ifc));
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct packed {logic d; logic wr; logic [3:0] s; logic [31:0] a; logic [31:0] w;} fld_t;
  typedef struct packed {logic d; logic [31:0] r;} rsp_t;
  fld_t       fq[$];
  rsp_t       rq[$];
  logic [4:0] cq[$];
  int n_chk = 0;
  int n_pass = 0;
  int ph = 0;
  bit g = 0, last = 0, i_pend = 0, d_pend = 0, p_aok = 0, p_dok = 0;
  logic [31:0] ia = 0;
  fld_t dfld = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(input bit rnd, input bit a_in, input bit d_in, input logic [31:0] rd_in);
    bit a, d, ea, ed;
    logic [31:0] rd;
    fld_t f;
    @(posedge clk);
    #1;
    if (ph == 0 && (i_pend || d_pend)) begin
      g = (RR && i_pend && d_pend) ? ~last : d_pend;
      last = g;
      f = g ? dfld : fld_t'({1'b0, 1'b0, 4'h0, ia, 32'h0});
      fq.push_back(f);
      ph = 1;
    end else if (ph == 1 && p_aok) begin
      if (g) d_pend = 0;
      else i_pend = 0;
      ph = p_dok ? 0 : 2;
    end else if (ph == 2 && p_dok) ph = 0;
    a = a_in;
    d = d_in;
    rd = rnd ? $urandom : rd_in;
    if (rnd) begin
      a = (ph == 1) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      d = (ph == 1) ? (a && $urandom % 4 == 0) : (ph == 2) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
    end
    ea = ph == 1 && a;
    ed = (ea && d) || (ph == 2 && d);
    ifc.bus_addr_ok = a;
    ifc.bus_data_ok = d;
    ifc.bus_rdata = rd;
    ifc.inst_req = i_pend;
    ifc.data_req = d_pend;
    if (!i_pend) ifc.inst_addr = $urandom;
    if (!d_pend) begin
      ifc.data_wr = 1'($urandom);
      ifc.data_wstrb = 4'($urandom);
      ifc.data_addr = $urandom;
      ifc.data_wdata = $urandom;
    end
    cq.push_back({ph == 1, ea && !g, ed && !g, ea && g, ed && g});
    if (ed) rq.push_back({g, rd});
    p_aok = a;
    p_dok = d;
  endtask

  task automatic issue_i(input logic [31:0] a);
    i_pend = 1;
    ia = a;
    ifc.inst_req = 1'b1;
    ifc.inst_addr = a;
  endtask

  task automatic issue_d(input bit wr, input logic [3:0] s, input logic [31:0] a, input logic [31:0] w);
    d_pend = 1;
    dfld = {1'b1, wr, s, a, w};
    ifc.data_req = 1'b1;
    ifc.data_wr = wr;
    ifc.data_wstrb = s;
    ifc.data_addr = a;
    ifc.data_wdata = w;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (i_pend || d_pend || ph != 0); k++) step(1, 0, 0, 0);
    chk("drain_timeout", 64'({i_pend, d_pend, ph != 0}), 64'(0));
  endtask

  initial begin
    fld_t cur;
    rsp_t r;
    bit pbr;
    cur = '0;
    pbr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) pbr = 0;
      else begin
        if (cq.size() > 0)
          chk("ctl{req,ia,id,da,dd}", 64'({ifc.bus_req, ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok}), 64'(cq.pop_front()));
        if (ifc.inst_data_ok || ifc.data_data_ok) begin
          if (rq.size() == 0) chk("rsp_unexpected", 64'({ifc.inst_data_ok, ifc.data_data_ok}), 64'(0));
          else begin
            r = rq.pop_front();
            chk("rsp_port", 64'(ifc.data_data_ok), 64'(r.d));
            chk("rsp_rdata", 64'(r.d ? ifc.data_rdata : ifc.inst_rdata), 64'(r.r));
          end
        end
        if (ifc.bus_req && !pbr) begin
          if (fq.size() == 0) chk("grant_unexpected", 64'(ifc.bus_req), 64'(0));
          else cur = fq.pop_front();
        end
        if (ifc.bus_req) begin
          chk("bus_wr", 64'(ifc.bus_wr), 64'(cur.wr));
          chk("bus_wstrb", 64'(ifc.bus_wstrb), 64'(cur.s));
          chk("bus_addr", 64'(ifc.bus_addr), 64'(cur.a));
          if (cur.d) chk("bus_wdata", 64'(ifc.bus_wdata), 64'(cur.w));
        end
        pbr = ifc.bus_req;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr;
    ifc.inst_req = 0; ifc.inst_addr = 0;
    ifc.data_req = 0; ifc.data_wr = 0; ifc.data_wstrb = 0; ifc.data_addr = 0; ifc.data_wdata = 0;
    ifc.bus_addr_ok = 1; ifc.bus_data_ok = 1; ifc.bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", 64'(ifc.bus_req), 64'(0));
    chk("rst_fields", 64'({ifc.bus_wr, ifc.bus_wstrb, ifc.bus_addr}), 64'(0));
    chk("rst_wdata", 64'(ifc.bus_wdata), 64'(0));
    chk("rst_oks", 64'({ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok}), 64'(0));
    ifc.bus_addr_ok = 0; ifc.bus_data_ok = 0;
    @(negedge clk);
    resetn = 1;
    step(0, 0, 0, 0); issue_i(32'hBFC00000);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h3C1D0001);
    step(0, 0, 0, 0); issue_d(1, 4'b1100, 32'h80000012, 32'hBEEFBEEF);
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h12345678);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      issue_i(32'h1000 + 32'(k * 4));
      issue_d(0, 4'h0, 32'h2000 + 32'(k * 4), 32'h0);
      drain();
    end
    step(0, 0, 0, 0); issue_d(0, 4'h0, 32'h00000040, 32'h0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'hA5A55A5A); issue_i(32'h00000080);
    step(0, 0, 0, 0);
    drain();
    step(0, 0, 0, 0); issue_i(32'h00000100);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    #1 ifc.bus_data_ok = 1;
    #1 resetn = 0;
    #1;
    chk("arst_bus_req", 64'(ifc.bus_req), 64'(0));
    chk("arst_oks", 64'({ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok, ifc.data_data_ok}), 64'(0));
    cq.delete(); rq.delete(); fq.delete();
    ph = 0; i_pend = 0; d_pend = 0; last = 0; p_aok = 0; p_dok = 0;
    ifc.inst_req = 0; ifc.data_req = 0; ifc.bus_data_ok = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
    step(0, 0, 1, 32'hDEADBEEF);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); issue_d(1, 4'hF, 32'h80001000, 32'hCAFEF00D);
    step(0, 0, 0, 0); issue_i(32'hBFC00010);
    repeat (10) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    drain();
    repeat (1500) begin
      step(1, 0, 0, 0);
      if (!i_pend && $urandom % 3 == 0) issue_i($urandom);
      if (!d_pend && $urandom % 3 == 0) begin
        wr = 1'($urandom);
        issue_d(wr, wr ? 4'($urandom_range(1, 15)) : 4'h0, $urandom, $urandom);
      end
    end
    drain();
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queues_empty", 64'(fq.size() + rq.size() + cq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
